k423_wb_arbiter: RTL and testbench

- Owns the single register-file write port at the writeback stage.
- Shares that port between two sources:
  - the in-order mem→wb pipeline result;
  - a long-latency unit result port (MDU/LSU refill), buffered in a small FIFO.
- Priority goes to the pipeline, backed by a starvation counter that guarantees forward progress for long-latency results.
- Drives the ready back-pressure seen by the mem→wb pipeline register.

---
 rtl/k423_wb_arbiter_if.sv | 37 +++
 rtl/k423_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_k423_wb_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/k423_wb_arbiter_if.sv
// Writeback arbiter bus: pipeline entry, long-latency result stream and register-file/retire outputs.
// The slave modport is the arbiter side. The master modport is the producer/consumer side.
interface k423_wb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5,
  parameter int ADDR_W = 32
);
  logic              pipe_vld_i;
  logic [ADDR_W-1:0] pipe_pc_i;
  logic              pipe_rd_vld_i;
  logic [RIDX_W-1:0] pipe_rd_idx_i;
  logic [XLEN-1:0]   pipe_rd_i;
  logic              pipe_rdy_o;
  logic              lu_vld_i;
  logic [RIDX_W-1:0] lu_rd_idx_i;
  logic [XLEN-1:0]   lu_rd_i;
  logic              lu_rdy_o;
  logic              rf_wr_en_o;
  logic [RIDX_W-1:0] rf_wr_idx_o;
  logic [XLEN-1:0]   rf_wr_data_o;
  logic              wb_retire_o;
  logic [ADDR_W-1:0] wb_pc_o;

  modport slave (
    input  pipe_vld_i, pipe_pc_i, pipe_rd_vld_i, pipe_rd_idx_i, pipe_rd_i,
    input  lu_vld_i, lu_rd_idx_i, lu_rd_i,
    output pipe_rdy_o, lu_rdy_o,
    output rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, wb_retire_o, wb_pc_o
  );

  modport master (
    output pipe_vld_i, pipe_pc_i, pipe_rd_vld_i, pipe_rd_idx_i, pipe_rd_i,
    output lu_vld_i, lu_rd_idx_i, lu_rd_i,
    input  pipe_rdy_o, lu_rdy_o,
    input  rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, wb_retire_o, wb_pc_o
  );
endinterface

// File: rtl/k423_wb_arbiter.sv
// Writeback register-file port arbiter: the pipeline has priority, and buffered long-latency results are forced through after MAX_WAIT blocked cycles.
// Optional macro K423_WB_ARB_PERF_EN enables the pipeline stall cycle counter on perf_stall_cnt_o.
module k423_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int RIDX_W   = 5,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  k423_wb_arbiter_if.slave bus,
  output logic [31:0]      perf_stall_cnt_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = RIDX_W + XLEN;
  localparam logic [3:0]       MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        wait_q, wait_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [RIDX_W-1:0] rf_wr_idx_q, rf_wr_idx_d;
  logic [XLEN-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic              wb_retire_q, wb_retire_d;
  logic [ADDR_W-1:0] wb_pc_q, wb_pc_d;

  logic [ENT_W-1:0]  head_s;
  logic              h_s, w_s, s_s;
  logic              grant_fifo_s, grant_pipe_s;
  logic              pipe_rdy_s, retire_s, lu_rdy_s, push_s, pop_s;

  assign head_s       = mem_q[rd_ptr_q];
  assign h_s          = (count_q != {CNT_W{1'b0}});
  assign w_s          = bus.pipe_vld_i & bus.pipe_rd_vld_i;
  assign s_s          = (wait_q == MAX_WAIT_C);
  assign grant_fifo_s = h_s & (~w_s | s_s);
  assign grant_pipe_s = ~grant_fifo_s & w_s;
  // The pipe stalls only when a starved result takes the port away from a writing entry.
  assign pipe_rdy_s   = ~(h_s & w_s & s_s);
  assign retire_s     = bus.pipe_vld_i & pipe_rdy_s;
  assign lu_rdy_s     = (count_q < DEPTH_C);
  assign push_s       = bus.lu_vld_i & lu_rdy_s;
  assign pop_s        = grant_fifo_s;

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Starvation counter and registered writeback outputs next state
  always_comb begin
    wait_d       = wait_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_idx_d  = {RIDX_W{1'b0}};
    rf_wr_data_d = {XLEN{1'b0}};
    wb_retire_d  = retire_s;
    wb_pc_d      = {ADDR_W{1'b0}};
    if (grant_fifo_s || !h_s) begin
      wait_d = 4'd0;
    end else if (!s_s) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
    if (grant_fifo_s) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_idx_d  = head_s[ENT_W-1:XLEN];
      rf_wr_data_d = head_s[XLEN-1:0];
    end else if (grant_pipe_s) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_idx_d  = bus.pipe_rd_idx_i;
      rf_wr_data_d = bus.pipe_rd_i;
    end else begin
      rf_wr_en_d   = 1'b0;
    end
    if (retire_s) begin
      wb_pc_d = bus.pipe_pc_i;
    end else begin
      wb_pc_d = {ADDR_W{1'b0}};
    end
  end

  // FIFO storage; contents are don't-care while the entry is not counted
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.lu_rd_idx_i, bus.lu_rd_i};
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      wait_q       <= 4'd0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_idx_q  <= {RIDX_W{1'b0}};
      rf_wr_data_q <= {XLEN{1'b0}};
      wb_retire_q  <= 1'b0;
      wb_pc_q      <= {ADDR_W{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_idx_q  <= rf_wr_idx_d;
      rf_wr_data_q <= rf_wr_data_d;
      wb_retire_q  <= wb_retire_d;
      wb_pc_q      <= wb_pc_d;
    end
  end

  assign bus.pipe_rdy_o   = pipe_rdy_s;
  assign bus.lu_rdy_o     = lu_rdy_s;
  assign bus.rf_wr_en_o   = rf_wr_en_q;
  assign bus.rf_wr_idx_o  = rf_wr_idx_q;
  assign bus.rf_wr_data_o = rf_wr_data_q;
  assign bus.wb_retire_o  = wb_retire_q;
  assign bus.wb_pc_o      = wb_pc_q;

`ifdef K423_WB_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;

  assign perf_d = (bus.pipe_vld_i & ~pipe_rdy_s) ? (perf_q + 32'd1) : perf_q;

  // Stall cycle counter, wraps naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt_o = perf_q;
`else
  assign perf_stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_k423_wb_arbiter.sv
// Directed bench for k423_wb_arbiter: expected writeback events are queued as stimulus is issued.
// A negedge monitor pops and compares an event whenever the DUT writes or retires.
module tb_k423_wb_arbiter;
  typedef struct packed {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        ret;
    logic [31:0] pc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] perf_stall_cnt_o;
  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          exp_stall = 0;
  logic        mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  k423_wb_arbiter_if #(.XLEN(32), .RIDX_W(5), .ADDR_W(32)) bus ();

  k423_wb_arbiter #(
    .XLEN(32), .RIDX_W(5), .ADDR_W(32), .DEPTH(2), .MAX_WAIT(3)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .bus              (bus),
    .perf_stall_cnt_o (perf_stall_cnt_o)
  );

  // Scoreboard monitor: every write or retire must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (mon_en && (bus.rf_wr_en_o === 1'b1 || bus.wb_retire_o === 1'b1)) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got en=%0b idx=%0d data=%h ret=%0b pc=%h, required no output",
                 bus.rf_wr_en_o, bus.rf_wr_idx_o, bus.rf_wr_data_o, bus.wb_retire_o, bus.wb_pc_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.rf_wr_en_o !== mon_e.en || bus.wb_retire_o !== mon_e.ret ||
            (mon_e.en && (bus.rf_wr_idx_o !== mon_e.idx || bus.rf_wr_data_o !== mon_e.data)) ||
            (mon_e.ret && bus.wb_pc_o !== mon_e.pc)) begin
          fails++;
          $display("FAIL wb_event: got en=%0b idx=%0d data=%h ret=%0b pc=%h, required en=%0b idx=%0d data=%h ret=%0b pc=%h",
                   bus.rf_wr_en_o, bus.rf_wr_idx_o, bus.rf_wr_data_o, bus.wb_retire_o, bus.wb_pc_o,
                   mon_e.en, mon_e.idx, mon_e.data, mon_e.ret, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "timeout");
  end

  function automatic void exp_push(input logic en, input logic [4:0] idx, input logic [31:0] data,
                                   input logic ret, input logic [31:0] pc);
    exp_t e;
    e.en = en; e.idx = idx; e.data = data; e.ret = ret; e.pc = pc;
    sb_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input string name,
                     input logic pv, input logic pw, input logic [4:0] pidx, input logic [31:0] pdata,
                     input logic [31:0] ppc,
                     input logic lv, input logic [4:0] lidx, input logic [31:0] ldata,
                     input logic exp_prdy, input logic exp_lrdy);
    bus.pipe_vld_i    = pv;
    bus.pipe_rd_vld_i = pw;
    bus.pipe_rd_idx_i = pidx;
    bus.pipe_rd_i     = pdata;
    bus.pipe_pc_i     = ppc;
    bus.lu_vld_i      = lv;
    bus.lu_rd_idx_i   = lidx;
    bus.lu_rd_i       = ldata;
    #1;
    chk({name, "_pipe_rdy"}, 32'(bus.pipe_rdy_o), 32'(exp_prdy));
    chk({name, "_lu_rdy"}, 32'(bus.lu_rdy_o), 32'(exp_lrdy));
    if (pv && !exp_prdy) exp_stall++;
    tick();
  endtask

  task automatic idle(input string name, input logic exp_lrdy);
    cyc(name, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, exp_lrdy);
  endtask

  task automatic chk_perf();
`ifdef K423_WB_ARB_PERF_EN
    chk("perf_cnt", perf_stall_cnt_o, 32'(exp_stall));
`else
    chk("perf_cnt", perf_stall_cnt_o, 32'd0);
`endif
  endtask

  initial begin
    bus.pipe_vld_i = 1'b0; bus.pipe_rd_vld_i = 1'b0; bus.pipe_rd_idx_i = 5'd0;
    bus.pipe_rd_i = 32'd0; bus.pipe_pc_i = 32'd0;
    bus.lu_vld_i = 1'b0; bus.lu_rd_idx_i = 5'd0; bus.lu_rd_i = 32'd0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    chk("rst_wr_idx", 32'(bus.rf_wr_idx_o), 32'd0);
    chk("rst_wr_data", bus.rf_wr_data_o, 32'd0);
    chk("rst_retire", 32'(bus.wb_retire_o), 32'd0);
    chk("rst_pc", bus.wb_pc_o, 32'd0);
    chk("rst_pipe_rdy", 32'(bus.pipe_rdy_o), 32'd1);
    chk("rst_lu_rdy", 32'(bus.lu_rdy_o), 32'd1);
    chk_perf();
    mon_en = 1'b1;

    // Pipe only: normal write, x0 passthrough, no-write retire
    exp_push(1'b1, 5'd5, 32'h0000_A5A5, 1'b1, 32'h100);
    cyc("pipe_wr", 1'b1, 1'b1, 5'd5, 32'h0000_A5A5, 32'h100, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 32'h104);
    cyc("pipe_x0", 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h104, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    exp_push(1'b0, 5'd0, 32'd0, 1'b1, 32'h108);
    cyc("pipe_nowr", 1'b1, 1'b0, 5'd3, 32'h1234, 32'h108, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle("idle0", 1'b1);

    // Parallel: FIFO result and no-write pipe entry in the same cycle
    cyc("par_load", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h11, 1'b1, 1'b1);
    exp_push(1'b1, 5'd7, 32'h11, 1'b1, 32'h200);
    cyc("par_nowr", 1'b1, 1'b0, 5'd0, 32'd0, 32'h200, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle("idle1", 1'b1);

    // Starvation: three pipe writes win, the fourth stalls for one cycle
    cyc("stv_load", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1);
    exp_push(1'b1, 5'd1, 32'h1001, 1'b1, 32'h300);
    cyc("stv_w1", 1'b1, 1'b1, 5'd1, 32'h1001, 32'h300, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd2, 32'h1002, 1'b1, 32'h304);
    cyc("stv_w2", 1'b1, 1'b1, 5'd2, 32'h1002, 32'h304, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd3, 32'h1003, 1'b1, 32'h308);
    cyc("stv_w3", 1'b1, 1'b1, 5'd3, 32'h1003, 32'h308, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd9, 32'h99, 1'b0, 32'd0);
    cyc("stv_w4_stall", 1'b1, 1'b1, 5'd4, 32'h1004, 32'h30C, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    exp_push(1'b1, 5'd4, 32'h1004, 1'b1, 32'h30C);
    cyc("stv_w4_go", 1'b1, 1'b1, 5'd4, 32'h1004, 32'h30C, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle("idle2", 1'b1);

    // Full FIFO under continuous pipe writes; the held third result enters after the first forced pop
    exp_push(1'b1, 5'd21, 32'h2001, 1'b1, 32'h400);
    cyc("full_c1", 1'b1, 1'b1, 5'd21, 32'h2001, 32'h400, 1'b1, 5'd10, 32'hA0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd22, 32'h2002, 1'b1, 32'h404);
    cyc("full_c2", 1'b1, 1'b1, 5'd22, 32'h2002, 32'h404, 1'b1, 5'd11, 32'hB0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd23, 32'h2003, 1'b1, 32'h408);
    cyc("full_c3", 1'b1, 1'b1, 5'd23, 32'h2003, 32'h408, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b0);
    exp_push(1'b1, 5'd24, 32'h2004, 1'b1, 32'h40C);
    cyc("full_c4", 1'b1, 1'b1, 5'd24, 32'h2004, 32'h40C, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b0);
    exp_push(1'b1, 5'd10, 32'hA0, 1'b0, 32'd0);
    cyc("full_c5", 1'b1, 1'b1, 5'd25, 32'h2005, 32'h410, 1'b1, 5'd12, 32'hC0, 1'b0, 1'b0);
    exp_push(1'b1, 5'd25, 32'h2005, 1'b1, 32'h410);
    cyc("full_c6", 1'b1, 1'b1, 5'd25, 32'h2005, 32'h410, 1'b1, 5'd12, 32'hC0, 1'b1, 1'b1);
    exp_push(1'b1, 5'd11, 32'hB0, 1'b0, 32'd0);
    idle("full_c7", 1'b0);
    exp_push(1'b1, 5'd12, 32'hC0, 1'b0, 32'd0);
    idle("full_c8", 1'b1);
    idle("full_c9", 1'b1);
    chk_perf();

    // Reset with a buffered result discards it
    cyc("rst_load", 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd13, 32'hD0, 1'b1, 1'b1);
    bus.lu_vld_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_stall = 0;
    chk("rst2_wr_en", 32'(bus.rf_wr_en_o), 32'd0);
    chk_perf();
    idle("rst2_idle0", 1'b1);
    idle("rst2_idle1", 1'b1);
    exp_push(1'b1, 5'd6, 32'h600D, 1'b1, 32'h500);
    cyc("rst2_pipe", 1'b1, 1'b1, 5'd6, 32'h600D, 32'h500, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    idle("rst2_idle2", 1'b1);
    idle("rst2_idle3", 1'b1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
